// File: rtl/agc_ctrl.sv
// Automatic gain controller: tracks the envelope of a monitored AXI-stream
// tap with attack/release smoothing and, once per block of accepted samples,
// nudges the gain-stage coefficient toward a target envelope level.
module agc_ctrl #(
  parameter int DW        = 24,
  parameter int COEFW     = 18,
  parameter int COEFQ     = 16,
  parameter int K_INIT    = 65536,
  parameter int ATK_SHIFT = 4,
  parameter int REL_SHIFT = 10,
  parameter int BLOCK_LEN = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DW-1:0]      s_axis_tdata,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  input  logic               enable,
  input  logic [DW-2:0]      target,
  input  logic [DW-2:0]      hyst,
  input  logic [COEFW-2:0]   step,
  input  logic [COEFW-1:0]   k_min,
  input  logic [COEFW-1:0]   k_max,
  output logic [COEFW-1:0]   k_out,
  output logic               k_update,
  output logic [DW-2:0]      env_out
);

  localparam int CNT_W = $clog2(BLOCK_LEN);

  // The coefficient must keep at least its sign bit above the binary point.
  if (COEFQ >= COEFW) begin : g_bad_coefq
    $error("agc_ctrl: COEFQ must be smaller than COEFW");
  end

  typedef enum logic [1:0] {ACCUM, COMPARE, ADJUST} state_t;

  state_t                    state_q, state_d;
  logic                      tready_q;
  logic [CNT_W-1:0]          count_q;
  logic [DW-2:0]             env_q;
  logic                      dir_dn_p1, dir_up_p1;
  logic signed [COEFW-1:0]   k_q;
  logic                      vld_p2;

  logic                      acc;
  logic                      last;
  logic [DW-1:0]             hi_lvl;
  logic [DW-2:0]             lo_lvl;

  // |x| in DW-1 bits; the most negative input saturates to full scale.
  function automatic logic [DW-2:0] mag_sat(input logic [DW-1:0] x);
    if (x[DW-1]) begin
      if (x[DW-2:0] == '0) return '1;
      return ~x[DW-2:0] + (DW-1)'(1);
    end
    return x[DW-2:0];
  endfunction

  // One smoothing step; the minimum step of 1 guarantees convergence and
  // the step never overshoots a, so env stays inside [0, 2^(DW-1)-1].
  function automatic logic [DW-2:0] env_step(input logic [DW-2:0] env,
                                             input logic [DW-2:0] a);
    logic [DW-2:0] d;
    if (a > env) begin
      d = (a - env) >> ATK_SHIFT;
      if (d == '0) d = (DW-1)'(1);
      return env + d;
    end else if (a < env) begin
      d = (env - a) >> REL_SHIFT;
      if (d == '0) d = (DW-1)'(1);
      return env - d;
    end
    return env;
  endfunction

  // k +/- step in one extra bit, then max(k_min) followed by min(k_max) so an
  // inverted clamp window resolves to k_max.
  function automatic logic signed [COEFW-1:0] k_adjust(
      input logic signed [COEFW-1:0] k,
      input logic                    up,
      input logic [COEFW-2:0]        st,
      input logic signed [COEFW-1:0] lo,
      input logic signed [COEFW-1:0] hi);
    logic signed [COEFW:0] kx, sx, lox, hix, v;
    kx  = {k[COEFW-1], k};
    sx  = {2'b00, st};
    lox = {lo[COEFW-1], lo};
    hix = {hi[COEFW-1], hi};
    v   = up ? kx + sx : kx - sx;
    if (v < lox) v = lox;
    if (v > hix) v = hix;
    return COEFW'(v);
  endfunction

  assign acc     = s_axis_tvalid && tready_q;
  assign last    = (count_q == CNT_W'(BLOCK_LEN - 1));
  assign hi_lvl  = {1'b0, target} + {1'b0, hyst};
  assign lo_lvl  = (target > hyst) ? (target - hyst) : '0;

  // Next-state: a block closes on its last accepted sample, then one cycle
  // each for the decision and the coefficient write.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:   if (acc && last) state_d = COMPARE;
      COMPARE: state_d = ADJUST;
      ADJUST:  state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  // Control: state, registered ready (low out of reset and while deciding)
  // and the block sample counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ACCUM;
      tready_q <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      tready_q <= (state_d == ACCUM);
      if (acc) count_q <= last ? '0 : count_q + CNT_W'(1);
    end
  end

  // Stage p0 -> p1: envelope tracking per accepted sample, decision in COMPARE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      env_q     <= '0;
      dir_dn_p1 <= 1'b0;
      dir_up_p1 <= 1'b0;
    end else begin
      if (acc) env_q <= env_step(env_q, mag_sat(s_axis_tdata));
      if (state_q == COMPARE) begin
        dir_dn_p1 <= ({1'b0, env_q} > hi_lvl);
        dir_up_p1 <= (env_q < lo_lvl);
      end
    end
  end

  // Stage p1 -> p2: coefficient write and its one-cycle update pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k_q    <= COEFW'(K_INIT);
      vld_p2 <= 1'b0;
    end else begin
      vld_p2 <= 1'b0;
      if (state_q == ADJUST && enable && (dir_dn_p1 || dir_up_p1)) begin
        k_q    <= k_adjust(k_q, dir_up_p1, step, k_min, k_max);
        vld_p2 <= 1'b1;
      end
    end
  end

  assign s_axis_tready = tready_q;
  assign k_out         = k_q;
  assign k_update      = vld_p2;
  assign env_out       = env_q;

endmodule

// File: tb/tb_agc_ctrl.sv
// Directed bench for agc_ctrl with a short block (4 samples) and instant attack.
module tb_agc_ctrl;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [23:0] s_tdata;
  logic               s_tvalid;
  logic               s_tready;
  logic               enable;
  logic [22:0]        target;
  logic [22:0]        hyst;
  logic [16:0]        step;
  logic signed [17:0] k_min;
  logic signed [17:0] k_max;
  logic [17:0]        k_out;
  logic               k_update;
  logic [22:0]        env_out;

  int n_chk  = 0;
  int n_fail = 0;

  agc_ctrl #(
    .DW(24), .COEFW(18), .COEFQ(16), .K_INIT(65536),
    .ATK_SHIFT(0), .REL_SHIFT(10), .BLOCK_LEN(4)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .enable(enable), .target(target), .hyst(hyst), .step(step),
    .k_min(k_min), .k_max(k_max),
    .k_out(k_out), .k_update(k_update), .env_out(env_out)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic signed [63:0] act,
                          input logic signed [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic send(input logic signed [23:0] v);
    int n;
    n = 0;
    s_tdata  = v;
    s_tvalid = 1'b1;
    while (!s_tready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("send_rdy", s_tready, 1);
    @(posedge clk);
    @(negedge clk);
    s_tvalid = 1'b0;
  endtask

  task automatic send_n(input logic signed [23:0] v, input int cnt);
    for (int i = 0; i < cnt; i++) send(v);
  endtask

  // Called at the negedge after the block's last handshake (edge N).
  task automatic check_adj(input string tag, input int exp_k, input bit exp_upd);
    check_eq({tag, "_rdy1"}, s_tready, 0);
    check_eq({tag, "_upd1"}, k_update, 0);
    @(negedge clk);
    check_eq({tag, "_rdy2"}, s_tready, 0);
    check_eq({tag, "_upd2"}, k_update, 0);
    @(negedge clk);
    check_eq({tag, "_k"}, $signed(k_out), exp_k);
    check_eq({tag, "_upd3"}, k_update, exp_upd);
    check_eq({tag, "_rdy3"}, s_tready, 1);
    @(negedge clk);
    check_eq({tag, "_upd4"}, k_update, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; s_tvalid = 1'b1; s_tdata = 24'sd1000;
    enable = 1'b1; target = 23'd500; hyst = 23'd100; step = 17'd1024;
    k_min = 18'sd0; k_max = 18'sd131071;

    // reset held with valid driven
    repeat (2) @(negedge clk);
    check_eq("rst_k", $signed(k_out), 65536);
    check_eq("rst_rdy", s_tready, 0);
    check_eq("rst_env", env_out, 0);
    check_eq("rst_upd", k_update, 0);
    rst = 1'b1; s_tvalid = 1'b0;
    @(negedge clk);
    check_eq("rel_rdy", s_tready, 1);
    check_eq("rel_upd", k_update, 0);

    // step up: env 0 below 400
    send_n(24'sd0, 4);
    check_eq("up_env", env_out, 0);
    check_adj("up", 66560, 1);

    // disabled: decision UP but no write
    enable = 1'b0;
    send_n(24'sd0, 4);
    check_adj("dis", 66560, 0);

    // dead-band: env 450 inside [400,600]
    enable = 1'b1;
    send_n(24'sd450, 4);
    check_eq("hold_env", env_out, 450);
    check_adj("hold", 66560, 0);

    // async reset restores coefficient and envelope
    rst = 1'b0;
    #1;
    check_eq("arst_k", $signed(k_out), 65536);
    check_eq("arst_env", env_out, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // step down
    hyst = 23'd0;
    send_n(24'sd1000, 4);
    check_eq("down_env", env_out, 1000);
    check_adj("down", 64512, 1);

    // clamp at k_min
    k_min = 18'sd64000;
    send_n(24'sd1000, 4);
    check_adj("clamp1", 64000, 1);
    send_n(24'sd1000, 4);
    check_adj("clamp2", 64000, 1);

    // magnitude saturation and slow release
    send(-24'sd8388608);
    check_eq("sat_env0", env_out, 8388607);
    send(24'sd0);
    check_eq("sat_env1", env_out, 8380416);
    send(24'sd0);
    check_eq("sat_env2", env_out, 8372232);
    send(24'sd0);
    check_eq("sat_env3", env_out, 8364056);
    check_adj("sat", 64000, 1);

    // reset during COMPARE: no pending update survives
    k_min = 18'sd0;
    send_n(24'sd1000, 4);
    rst = 1'b0;
    #1;
    check_eq("mrst_k", $signed(k_out), 65536);
    check_eq("mrst_env", env_out, 0);
    check_eq("mrst_rdy", s_tready, 0);
    check_eq("mrst_upd", k_update, 0);
    @(negedge clk);
    check_eq("mrst_upd2", k_update, 0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mrst_upd3", k_update, 0);
    check_eq("mrst_k3", $signed(k_out), 65536);
    check_eq("mrst_rdy3", s_tready, 1);
    @(negedge clk);
    check_eq("mrst_upd4", k_update, 0);
    check_eq("mrst_k4", $signed(k_out), 65536);

    // valid gaps: decision only after the fourth accepted sample
    send(24'sd1000);
    check_eq("gap_env", env_out, 1000);
    repeat (3) @(negedge clk);
    check_eq("gap_env_hold", env_out, 1000);
    check_eq("gap_rdy", s_tready, 1);
    send(24'sd1000);
    send(24'sd1000);
    @(negedge clk);
    check_eq("gap_rdy3", s_tready, 1);
    check_eq("gap_upd3", k_update, 0);
    send(24'sd1000);
    check_adj("gap", 64512, 1);

    // inverted clamp window resolves to k_max
    k_min = 18'sd70000;
    k_max = 18'sd60000;
    send_n(24'sd1000, 4);
    check_adj("kinv", 60000, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/agc_ctrl.md
Name: agc_ctrl

Overview:
- Automatic gain controller: the producer of the coefficient that the gain stage consumes.
- Monitors an AXI-stream sample tap and tracks the signal envelope with attack/release smoothing.
- Once per block of samples, compares the envelope to a target level and steps the output coefficient up or down.
- Output drives the gain stage's k input directly: same COEFW width, same COEFQ fixed-point format.

Parameters:
DW, 24, sample width (signed)
COEFW, 18, coefficient width (signed)
COEFQ, 16, coefficient fractional bits
K_INIT, 65536, reset coefficient value (1.0 at COEFQ=16)
ATK_SHIFT, 4, attack smoothing shift
REL_SHIFT, 10, release smoothing shift
BLOCK_LEN, 256, accepted samples per adjustment decision (>=2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
s_axis_tdata  in  DW  signed monitored sample
s_axis_tvalid  in  1  sample valid
s_axis_tready  out  1  sample accepted when valid&&ready
enable  in  1  1 = adjustments allowed
target  in  DW-1  unsigned target envelope level
hyst  in  DW-1  unsigned dead-band half-width
step  in  COEFW-1  unsigned coefficient increment
k_min  in  COEFW  signed lower clamp
k_max  in  COEFW  signed upper clamp
k_out  out  COEFW  signed coefficient, COEFQ fractional bits
k_update  out  1  one-cycle pulse when k_out was rewritten
env_out  out  DW-1  current envelope (debug/metering)

Behaviour:
- Reset (rst low, asynchronous):
  - k_out=K_INIT, env=0, count=0, state=ACCUM.
  - k_update=0, s_axis_tready=0.
  - On the first edge after release, tready=1.
- Magnitude:
  - a = |tdata|.
  - tdata = -2^(DW-1) saturates to 2^(DW-1)-1.
  - a is DW-1 bits unsigned.
- Envelope update, on each accepted sample only:
  - If a>env: env += max(1, (a-env)>>ATK_SHIFT).
  - If a<env: env -= max(1, (env-a)>>REL_SHIFT).
  - If a==env: hold.
  - env never leaves [0, 2^(DW-1)-1].
- count increments per accepted sample.
- States:
  - ACCUM: tready=1.
    - On an accepted sample with count==BLOCK_LEN-1: count<=0, state<=COMPARE.
  - COMPARE (1 cycle): tready=0.
    - Snapshot env (including the last sample), target and hyst.
    - dir=DOWN if env > target+hyst.
    - dir=UP if env < target-hyst, where target-hyst saturates at 0; if target==0 and hyst>=0, UP is never chosen.
    - Otherwise dir=HOLD.
    - target+hyst is computed in DW bits (no overflow).
    - state<=ADJUST.
  - ADJUST (1 cycle): tready=0.
    - If enable and dir!=HOLD: k_out <= min(max(k_out ± step, k_min), k_max), computed in COEFW+1 bits signed; k_update<=1.
    - Otherwise k_out unchanged and k_update stays 0.
    - state<=ACCUM.
- Latency:
  - Handshake of the block's last sample at edge N.
  - COMPARE executes at edge N+1.
  - k_out and k_update change at edge N+2.
  - k_update deasserts at edge N+3.
  - tready is low during the two cycles following edge N.
- Clamp rules:
  - If k_min>k_max, the result equals k_max (max applied first, then min).
  - Clamp applies only on ADJUST, never retroactively.
- enable=0: envelope and block counting continue; only k_out writes are suppressed.
- tvalid low: nothing advances; count and env hold.
- Inputs target, hyst, step, k_min, k_max, enable are sampled only in COMPARE/ADJUST.
- Reset asserted mid-block or in COMPARE/ADJUST: immediate return to reset values. No pending update is applied.

Test Plan:
- Reset: hold rst low, drive tvalid -> k_out=65536, tready=0, env_out=0; after release tready=1 next cycle, k_update=0.
- Step down (BLOCK_LEN=4, ATK_SHIFT=0, target=500, hyst=0, step=1024, k_min=0, k_max=131071, enable=1): four samples of 1000 -> env_out=1000; k_out=64512 two edges after the 4th handshake; one k_update pulse; tready low exactly 2 cycles.
- Clamp: continue the previous scenario with k_min=64000 -> next block k_out=64000 (not 63488); a further block stays 64000 and k_update still pulses.
- Step up / dead-band / hold: samples 0 with target=500, hyst=100, step=1024 -> k_out +1024. Samples settling env=450 -> HOLD, no pulse. enable=0 with env=0 -> k_out unchanged, no pulse.
- Saturation: a sample of -8388608 with ATK_SHIFT=0 -> env_out=8388607. Then zeros with REL_SHIFT=10 -> env decreases by 8191 on the first sample and by at least 1 per sample thereafter.
- Mid-operation reset and backpressure gaps: drop rst during COMPARE -> k_out=65536 asynchronously, no k_update. tvalid toggled 1-0-1 -> decision only after 4 accepted samples.
